jtag_shift_controller: RTL and testbench



---
 rtl/jtag_shift_controller.sv | 143 ++++++++++++++
 tb/tb_jtag_shift_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_controller.sv
// JTAG master sequencer: walks one target TAP through IR/DR scans or a TAP reset,
// shifting cmd_data out LSB-first on Tdi and returning the captured Tdo bits.
module jtag_shift_controller #(
  parameter int MAX_LEN      = 32,
  parameter int LEN_W        = 6,
  parameter int RESET_CYCLES = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_tap_reset,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               Tms,
  output logic               Tdi,
  input  logic               Tdo
);

  localparam int RC_W  = $clog2(RESET_CYCLES + 1);
  localparam int CNT_W = (RC_W > LEN_W) ? RC_W : LEN_W;

  typedef enum logic [3:0] {
    TLR, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RESP
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [LEN_W-1:0]   len_q;
  logic               ir_q;
  logic               tap_q;
  logic [MAX_LEN-1:0] sh_q;
  logic [MAX_LEN-1:0] mask_q;
  logic               accept;
  logic               len_bad;
  logic               shift_data;
  logic               shift_data_nxt;

  // Tms value held during a cycle, keyed by the state owning that cycle.
  // SHIFT with cnt==0 is the entry cycle; cnt==i+1 carries data bit i.
  function automatic logic tms_of(state_t s, logic [CNT_W-1:0] c, logic [LEN_W-1:0] n);
    case (s)
      TLR:                 return c != CNT_W'(RESET_CYCLES);
      SEL_DR, SEL_IR, EXIT1: return 1'b1;
      SHIFT:               return c == CNT_W'(n);
      default:             return 1'b0;
    endcase
  endfunction

  assign cmd_ready      = (state == IDLE);
  assign rsp_valid      = (state == RESP);
  assign busy           = !(state inside {IDLE, RESP});
  assign accept         = cmd_valid && (state == IDLE);
  assign len_bad        = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));
  assign shift_data     = (state == SHIFT) && (cnt != '0);
  assign shift_data_nxt = (state_nxt == SHIFT) && (cnt_nxt != '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      TLR: begin
        if (cnt == CNT_W'(RESET_CYCLES)) begin
          state_nxt = tap_q ? RESP : IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          cnt_nxt = '0;
          if (cmd_tap_reset)  state_nxt = TLR;
          else if (len_bad)   state_nxt = RESP;
          else                state_nxt = SEL_DR;
        end
      end
      SEL_DR:  state_nxt = ir_q ? SEL_IR : CAPTURE;
      SEL_IR:  state_nxt = CAPTURE;
      CAPTURE: begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
      end
      SHIFT: begin
        if (cnt == CNT_W'(len_q)) begin
          state_nxt = EXIT1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      EXIT1:   state_nxt = UPDATE;
      UPDATE:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = TLR;
    endcase
  end

  // Control, pins and response: registered outputs track the next cycle's state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TLR;
      cnt      <= '0;
      tap_q    <= 1'b0;
      Tms      <= 1'b1;
      Tdi      <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Tms   <= tms_of(state_nxt, cnt_nxt, len_q);
      Tdi   <= shift_data_nxt ? sh_q[0] : 1'b0;
      if (accept) begin
        tap_q    <= cmd_tap_reset;
        rsp_err  <= !cmd_tap_reset && len_bad;
        rsp_data <= '0;
      end else if (shift_data && Tdo) begin
        rsp_data <= rsp_data | mask_q;
      end
    end
  end

  // Command latch and shift datapath.
  always_ff @(posedge clk) begin
    if (accept) begin
      len_q  <= cmd_len;
      ir_q   <= cmd_ir;
      sh_q   <= cmd_data;
      mask_q <= MAX_LEN'(1);
    end else begin
      if (shift_data_nxt) sh_q   <= sh_q >> 1;
      if (shift_data)     mask_q <= mask_q << 1;
    end
  end

endmodule

// File: tb/tb_jtag_shift_controller.sv
// Bench for jtag_shift_controller: per-cycle expectations built from the scan
// rules (Tms/Tdi timelines and expected capture) and compared on every negedge.
module tb_jtag_shift_controller;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam int RC      = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_tap_reset = 1'b0;
  logic               cmd_ir = 1'b0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               Tms;
  logic               Tdi;
  logic               Tdo = 1'b0;

  jtag_shift_controller #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .RESET_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tap_reset(cmd_tap_reset), .cmd_ir(cmd_ir), .cmd_len(cmd_len),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .Tms(Tms), .Tdi(Tdi),
    .Tdo(Tdo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tms, tdi, ready, busy, rvalid, chk_rsp, rerr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] seen_rdata = '0;
  logic        seen_rerr = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("Tms", 32'(Tms), 32'(e.tms));
      chk("Tdi", 32'(Tdi), 32'(e.tdi));
      chk("cmd_ready", 32'(cmd_ready), 32'(e.ready));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e.rvalid));
      if (e.chk_rsp) begin
        chk("rsp_data", rsp_data, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.rerr));
      end
      if (rsp_valid) begin
        seen_rdata = rsp_data;
        seen_rerr  = rsp_err;
      end
    end
  end

  task automatic push(logic tms, logic tdi, logic ready, logic bsy, logic rv,
                      logic chkr, logic [31:0] rd, logic re);
    exp_t x;
    x.tms = tms; x.tdi = tdi; x.ready = ready; x.busy = bsy; x.rvalid = rv;
    x.chk_rsp = chkr; x.rdata = rd; x.rerr = re;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the first edge that sampled reset=1.
  task automatic reset_tail(int held);
    repeat (held - 1) begin
      push(1, 0, 0, 1, 0, 1, 0, 0);
      step();
    end
    reset = 1'b0;
    repeat (RC) begin
      Tdo = 1'($urandom);
      push(1, 0, 0, 1, 0, 1, 0, 0);
      step();
    end
    push(0, 0, 0, 1, 0, 1, 0, 0);
    step();
  endtask

  task automatic resp_phase(logic [31:0] rd, logic re, int delay);
    rsp_ready = 1'b0;
    repeat (delay) begin
      push(0, 0, 0, 0, 1, 1, rd, re);
      step();
    end
    rsp_ready     = 1'b1;
    cmd_valid     = 1'b1;   // must be ignored: cmd_ready is low in RESP
    cmd_tap_reset = 1'b0;
    cmd_len       = '0;
    push(0, 0, 0, 0, 1, 1, rd, re);
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    push(0, 0, 1, 0, 0, 0, 0, 0);
    step();
  endtask

  // kind: 0 DR scan, 1 IR scan, 2 TAP reset. abort_at >= 0 raises reset in that cycle.
  task automatic run_cmd(int kind, int len, logic [31:0] data, logic [31:0] tdo,
                         int delay, int abort_at);
    logic        tq[$];
    logic        dq[$];
    int          sq[$];
    logic        legal;
    logic [31:0] mask;
    logic [31:0] rd;
    legal = (kind == 2) || (len >= 1 && len <= MAX_LEN);
    if (kind == 2) begin
      repeat (RC) begin tq.push_back(1); dq.push_back(0); sq.push_back(-1); end
      tq.push_back(0); dq.push_back(0); sq.push_back(-1);
    end else if (legal) begin
      tq.push_back(1); dq.push_back(0); sq.push_back(-1);
      if (kind == 1) begin tq.push_back(1); dq.push_back(0); sq.push_back(-1); end
      repeat (2) begin tq.push_back(0); dq.push_back(0); sq.push_back(-1); end
      for (int i = 0; i < len; i++) begin
        tq.push_back(i == len - 1); dq.push_back(data[i]); sq.push_back(i);
      end
      tq.push_back(1); dq.push_back(0); sq.push_back(-1);
      tq.push_back(0); dq.push_back(0); sq.push_back(-1);
    end
    cmd_valid     = 1'b1;
    cmd_ir        = (kind == 1);
    cmd_tap_reset = (kind == 2);
    cmd_len       = LEN_W'(len);
    cmd_data      = data;
    push(0, 0, 1, 0, 0, 0, 0, 0);
    step();
    cmd_valid = 1'b0;
    cmd_data  = 32'($urandom);
    for (int k = 0; k < tq.size(); k++) begin
      Tdo = (sq[k] >= 0) ? tdo[sq[k]] : 1'($urandom);
      push(tq[k], dq[k], 0, 1, 0, 0, 0, 0);
      if (k == abort_at) begin
        reset = 1'b1;
        step();
        return;
      end
      step();
    end
    mask = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    rd   = (kind != 2 && legal) ? (tdo & mask) : 32'd0;
    resp_phase(rd, !legal, delay);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, len;
    logic [31:0] d;
    reset = 1'b1;
    step();
    reset_tail(2);

    // Loopback target with a 1-bit delay that starts at 1.
    run_cmd(0, 8, 32'hA5, {32'hA5 << 1} | 32'd1, 0, -1);
    chk("pin_dr_a5", seen_rdata, 32'h4B);
    run_cmd(1, 4, 32'h3, 32'hFFFF_FFFF, 1, -1);
    chk("pin_ir_f", seen_rdata, 32'hF);
    run_cmd(0, 0, 32'h1234, 32'hFFFF_FFFF, 0, -1);
    chk("pin_len0_err", 32'(seen_rerr), 32'd1);
    run_cmd(0, 33, 32'h5678, 32'hFFFF_FFFF, 2, -1);
    chk("pin_len33_data", seen_rdata, 32'd0);
    run_cmd(0, 32, 32'hFFFF_FFFF, 32'hC3A5_0F96, 10, -1);
    chk("pin_len32", seen_rdata, 32'hC3A5_0F96);
    run_cmd(2, 7, 32'hFF, 32'hFFFF_FFFF, 1, -1);
    run_cmd(0, 1, 32'h1, 32'h1, 0, -1);
    chk("pin_len1", seen_rdata, 32'h1);

    // Reset during shift bit 3 of a 16-bit DR scan (preamble is 3 cycles).
    run_cmd(0, 16, 32'hBEEF, 32'hFFFF_FFFF, 0, 3 + 3);
    reset_tail(2);
    run_cmd(1, 12, 32'hABC, 32'h0000_0F0F, 0, -1);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      d    = $urandom;
      if (kind == 3) begin
        kind = $urandom_range(0, 1);
        len  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63);
      end else begin
        len = $urandom_range(1, MAX_LEN);
      end
      run_cmd(kind, len, d, $urandom, $urandom_range(0, 3), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
